// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encodings,
// default timing/depth parameters and the CPU-visible TX address.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int          CLKS_PER_BIT_DEFAULT = 434;
    localparam int          FIFO_DEPTH_DEFAULT   = 4;
    localparam logic [15:0] UART_TX_ADDR         = 16'h0ff0;

    // Baud counter counts down to zero, so a bit lasts reload+1 cycles.
    function automatic logic [15:0] baud_reload(input int clks_per_bit);
        return 16'(clks_per_bit - 1);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word-fall-through output and a sticky overflow flag.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  mem_q [DEPTH];
    logic        overflow_q;
    logic        wr_en;
    logic        rd_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout     = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

    // A pop on the same edge frees the slot the push lands in.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !wr_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed by the memory I/O decoder write strobe: edge-detects
// writes into a FIFO and serializes bytes as 8N1 frames, LSB first.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_tx_byte,
    input  logic       uart_we,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow,
    output logic [1:0] dbg_state_o
);

    localparam logic [15:0] RELOAD = baud_reload(CLKS_PER_BIT);

    tx_state_e   state_q;
    logic        we_q;
    logic [15:0] cnt_q;
    logic [2:0]  bi_q;
    logic [7:0]  sh_q;
    logic        tx_q;

    logic        push;
    logic        pop;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_overflow;

    // The decoder may hold the strobe for several cycles; only its rising
    // edge is a write.
    assign push = uart_we && !we_q;

    // Popping only from a non-empty FIFO keeps push/pop-while-empty impossible.
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) ||
                  ((state_q == ST_STOP) && (cnt_q == 16'd0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q <= 1'b0;
        end else begin
            we_q <= uart_we;
        end
    end

    uart_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (uart_tx_byte),
        .pop      (pop),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    // tx_q is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            bi_q    <= 3'd0;
            sh_q    <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        sh_q    <= fifo_dout;
                        cnt_q   <= RELOAD;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q   <= RELOAD;
                        bi_q    <= 3'd0;
                        tx_q    <= sh_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= RELOAD;
                        sh_q  <= {1'b0, sh_q[7:1]};
                        if (bi_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bi_q <= bi_q + 3'd1;
                            tx_q <= sh_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == 16'd0) begin
                        if (pop) begin
                            sh_q    <= fifo_dout;
                            cnt_q   <= RELOAD;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx          = tx_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign full        = fifo_full;
    assign overflow    = fifo_overflow;
    assign dbg_state_o = state_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Memory-mapped UART transmitter that sits directly downstream of the memory I/O decoder. It consumes the `uart_tx_byte` / `uart_we` pair the decoder produces for CPU writes to address 0x0ff0. Accepted bytes are buffered in a small FIFO and serialized on `tx` as 8N1 frames, LSB first, at a fixed baud set by a clock divider. Status outputs let the CPU poll for space and detect dropped bytes.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 4: byte entries; power of two, 2..16.

Ports:
- `clk`  in  1  system clock; everything is in this single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `uart_tx_byte`  in  8  byte from the memory I/O decoder.
- `uart_we`  in  1  write strobe from the decoder; may stay high for several cycles per CPU write.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is in flight or the FIFO is non-empty.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.

## Operation
- **Write detection.**
  - `uart_we` is registered into `we_q`.
  - A push occurs on the clock edge where `uart_we`=1 and `we_q`=0.
  - The push captures `uart_tx_byte` at that edge.
  - Holding `uart_we` high pushes exactly one byte.
- **FIFO.**
  - Circular buffer with read/write pointers one bit wider than the index; full/empty are derived from the pointer MSBs.
  - Push while full: the byte is discarded and `overflow` is set. Only reset clears `overflow`.
  - Push and pop on the same edge while full: both take effect, `full` stays 1, and `overflow` is not set.
  - Push and pop on the same edge while empty cannot occur, because the FSM pops only when the FIFO was already non-empty.
- **FSM states: IDLE, START, DATA, STOP.**
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into shift register `sh`, load the baud counter with `CLKS_PER_BIT-1`, and go to START.
  - START: `tx`=0. When the counter reaches 0, reload it, clear bit index `bi`, and go to DATA.
  - DATA: `tx`=`sh[0]`. When the counter reaches 0, reload it and shift `sh` right. If `bi`=7, go to STOP; otherwise increment `bi`.
  - STOP: `tx`=1. When the counter reaches 0 and the FIFO is non-empty, pop, reload, and go directly to START (no idle cycle). Otherwise go to IDLE.
- **Arithmetic.**
  - The baud counter is 16 bits and counts down. `bi` is 3 bits.
  - `tx` is driven from a register, never combinationally.
- **`busy`** = (state != IDLE) OR FIFO non-empty.

## Timing
- **Reset values** (asynchronous on `rst_n`=0):
  - Outputs: `tx`=1, `busy`=0, `full`=0, `overflow`=0.
  - Internal: state IDLE, both pointers 0, `we_q`=0, counter 0.
- **Reset mid-frame:** `tx` returns high immediately, the frame is abandoned, and FIFO contents are lost.
- **Latency:** with the FIFO empty and FSM in IDLE, a push at edge N gives the pop at edge N+1. `tx` falls after edge N+1.
- **Bit timing:**
  - Each of start, 8 data bits and stop lasts exactly `CLKS_PER_BIT` cycles.
  - A frame is `10*CLKS_PER_BIT` cycles.
  - Back-to-back frames have no gap.
- **Status timing:**
  - `full` rises after the edge of the push that fills the FIFO.
  - `full` falls after the edge of the pop.
  - `overflow` rises after the edge of the dropped push.
- **`busy` deassertion:** after the edge that leaves STOP into IDLE with the FIFO empty.

## Structure
- Shared include `uart_defs`: FSM state encodings (2-bit), `CLKS_PER_BIT` default, UART TX address 0x0ff0.
- Sub-module `uart_fifo`:
  - Parameter: depth.
  - Ports: `clk`, `rst_n`, push, `din[7:0]`, pop, `dout[7:0]`, `full`, `empty`, `overflow`.
  - `dout` is combinational from the read pointer (first-word-fall-through).
- Top level `uart_tx`: edge detect, baud counter, FSM, shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Single byte.** Push 0xA5 with a 1-cycle `uart_we` -> `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `tx` falls 1 edge after the push. `busy` lasts 41 cycles.
- **Held strobe.** `uart_we` high for 10 cycles carrying 0x41 -> exactly one frame; FIFO count never exceeds 1.
- **Back-to-back.** Push 0x01, 0x02, 0x03 on separate strobes -> three 40-cycle frames with no idle cycles between stop and start.
- **Overflow.**
  - Push 6 bytes 0x10..0x15, one strobe every 2 cycles, starting from idle.
  - Required: 0x10 pops immediately, so 0x11..0x14 fill the FIFO (`full`=1) and 0x15 is dropped.
  - `overflow`=1 and stays 1 after all frames finish. Transmitted bytes are 0x10..0x14.
- **Full with simultaneous pop.** Push on the exact edge STOP pops while full -> byte accepted, `overflow` stays 0.
- **Reset mid-frame.** Assert `rst_n`=0 during DATA bit 3 -> `tx`=1 immediately, and `busy`/`full`/`overflow`=0. After release, a new push of 0x55 transmits correctly.
